// File: rtl/bank_arbiter_if.sv
// bank_arbiter_if: requester handshake and bank-side bus of the shared-bank arbiter
interface bank_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] req, req_we, grant, done, err;
  logic [8*NUM_REQ-1:0] req_addr, req_wdata;
  logic [7:0] rdata, bank_addr, bank_wdata, bank_rdata;
  logic bank_read, bank_write, bank_finish;
  modport master (
    output req, req_we, req_addr, req_wdata, bank_rdata, bank_finish,
    input grant, done, err, rdata, bank_read, bank_write, bank_addr, bank_wdata
  );
  modport slave (
    input req, req_we, req_addr, req_wdata, bank_rdata, bank_finish,
    output grant, done, err, rdata, bank_read, bank_write, bank_addr, bank_wdata
  );
endinterface

// File: rtl/bank_arbiter.sv
// bank_arbiter: round-robin arbiter sharing one 256x8 bank between NUM_REQ requesters
module bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  bank_arbiter_if.slave bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_idx, w_win;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0] r_addr, r_wdata, r_rdata, r_cnt;
  logic r_we, r_err, w_any, w_to, w_strobe;
  assign w_any = |bus.req;
  assign w_to = r_cnt == 8'(TIMEOUT - 1);
  // scan downward so the requester closest above the pointer wins
  always_comb begin
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(r_ptr) + k) % NUM_REQ]) w_win = IW'((int'(r_ptr) + k) % NUM_REQ);
  end
  always_comb begin
    w_next = r_state == IDLE ? (w_any ? ISSUE : IDLE) :
             r_state == ISSUE ? WAIT :
             r_state == WAIT ? (bus.bank_finish || w_to ? RESP : WAIT) : IDLE;
    w_strobe = r_state == ISSUE || r_state == WAIT;
    bus.grant = r_grant;
    bus.done = (r_state == RESP && !r_err) ? r_grant : '0;
    bus.err = (r_state == RESP && r_err) ? r_grant : '0;
    bus.rdata = r_rdata;
    bus.bank_read = w_strobe && !r_we;
    bus.bank_write = w_strobe && r_we;
    bus.bank_addr = r_addr;
    bus.bank_wdata = r_wdata;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_idx <= '0;
      r_grant <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_idx <= w_win;
        r_grant <= ONE << w_win;
        r_we <= bus.req_we[w_win];
        r_addr <= bus.req_addr[8*int'(w_win) +: 8];
        r_wdata <= bus.req_wdata[8*int'(w_win) +: 8];
      end
      if (r_state == ISSUE) r_cnt <= '0;
      if (r_state == WAIT && bus.bank_finish) begin
        r_err <= 1'b0;
        if (!r_we) r_rdata <= bus.bank_rdata;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_to) r_err <= 1'b1;
      end
      if (r_state == RESP) begin
        r_grant <= '0;
        r_ptr <= (r_idx == IW'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bank_arbiter.sv
// tb_bank_arbiter: directed and randomized checks of bank_arbiter against a transaction-level model
module tb_bank_arbiter;
  localparam int N = 4;
  localparam int TO = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  bank_arbiter_if #(.NUM_REQ(N)) bus ();
  bank_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (.clock(clock), .reset(reset), .bus(bus));
  logic [7:0] mem [256];
  logic [7:0] rm [256];
  logic [7:0] exp_rd = 8'h00;
  logic [31:0] ord = 0;
  logic fin_r, stray = 1'b0;
  int scnt, lat = 1, ptr_m = 0, n_chk = 0, n_err = 0;
  // bank: finish rises after the strobe has been sampled lat times; lat=0 never finishes
  always_ff @(posedge clock) begin
    if (bus.bank_write) mem[bus.bank_addr] <= bus.bank_wdata;
    if (reset || !(bus.bank_read || bus.bank_write)) begin
      scnt <= 0;
      fin_r <= 1'b0;
    end else begin
      scnt <= scnt + 1;
      fin_r <= lat != 0 && scnt + 1 >= lat;
    end
  end
  assign bus.bank_finish = fin_r | stray;
  assign bus.bank_rdata = bus.bank_read ? mem[bus.bank_addr] : 8'hxx;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic setup(input int i, input logic w, input logic [7:0] ad, input logic [7:0] dt);
    bus.req_we[i] = w;
    bus.req_addr[8*i +: 8] = ad;
    bus.req_wdata[8*i +: 8] = dt;
  endtask
  function automatic int winner(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return -1;
  endfunction
  // serve ngr grants; held requesters keep req high after their done
  task automatic batch(input logic [N-1:0] mask, input logic [N-1:0] hold, input int ngr, input bit rnd);
    int served = 0, guard = 0, cur = -1, t = 0, clat = 0, w;
    logic cwe;
    logic [7:0] caddr, cwd;
    bit ok;
    ord = 0;
    bus.req = bus.req | mask;
    while (served < ngr && guard < 400) begin
      @(negedge clock);
      guard++;
      chk("exclusive", {$onehot0(bus.grant), $onehot0(bus.done), $onehot0(bus.err),
          !(bus.bank_read && bus.bank_write)}, 4'hF);
      if (cur < 0 && bus.grant != 0) begin
        w = winner(bus.req);
        chk("grant", 32'(bus.grant), w < 0 ? 0 : 1 << w);
        if (served == 0) chk("first_grant_cycle", guard, 1);
        cur = w < 0 ? 0 : w;
        cwe = bus.req_we[cur];
        caddr = bus.req_addr[8*cur +: 8];
        cwd = bus.req_wdata[8*cur +: 8];
        clat = lat;
        t = 0;
        stray = 1'b0;
        chk("issue_strobes", {bus.bank_read, bus.bank_write}, {!cwe, cwe});
        chk("issue_addr", {bus.bank_addr, bus.bank_wdata}, {caddr, cwd});
        if (rnd) begin
          bus.req_addr[8*cur +: 8] = 8'($urandom_range(8'hF0, 8'hFF));
          bus.req_wdata[8*cur +: 8] = 8'($urandom);
        end
      end else if (cur >= 0) begin
        t++;
        if ((bus.done | bus.err) == 0) begin
          chk("wait_strobes", {bus.bank_read, bus.bank_write, bus.bank_addr}, {!cwe, cwe, caddr});
        end else begin
          ok = clat != 0 && clat <= TO;
          chk("done", 32'(bus.done), ok ? 1 << cur : 0);
          chk("err", 32'(bus.err), ok ? 0 : 1 << cur);
          chk("latency", t, (ok ? clat : TO) + 1);
          chk("resp_strobes", {bus.bank_read, bus.bank_write}, 0);
          if (cwe) rm[caddr] = cwd;
          else if (ok) exp_rd = rm[caddr];
          chk("rdata", 32'(bus.rdata), 32'(exp_rd));
          ord = {ord[27:0], 4'(cur + 1)};
          ptr_m = (cur + 1) % N;
          served++;
          if (!hold[cur]) bus.req[cur] = 1'b0;
          cur = -1;
          if (rnd) lat = $urandom_range(0, 4);
        end
      end else if (rnd) begin
        stray = $urandom_range(0, 3) == 0;
      end
    end
    chk("batch_served", served, ngr);
    bus.req = '0;
    stray = 1'b0;
    @(negedge clock);
    chk("pulse_end", {bus.grant, bus.done, bus.err}, 0);
  endtask
  initial begin
    logic [N-1:0] m, h;
    bus.req = '0;
    bus.req_we = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clock);
    chk("rst_grant_done_err", {bus.grant, bus.done, bus.err}, 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    chk("rst_bank", {bus.bank_read, bus.bank_write, bus.bank_addr, bus.bank_wdata}, 0);
    reset = 1'b0;
    for (int i = 0; i < N; i++) setup(i, 1'b1, 8'(8'h20 + i), 8'(8'h50 + i));
    batch(4'b1111, 4'b0000, 4, 1'b0);
    chk("rr_order", ord, 32'h1234);
    setup(0, 1'b1, 8'h30, 8'h11);
    setup(2, 1'b1, 8'h32, 8'h22);
    batch(4'b0101, 4'b0101, 4, 1'b0);
    chk("fair_order", ord, 32'h1313);
    setup(0, 1'b0, 8'h20, 8'h00);
    batch(4'b0001, 4'b0000, 1, 1'b0);
    chk("wrap_order", ord, 32'h1);
    chk("wrap_rdata", 32'(bus.rdata), 32'h50);
    setup(1, 1'b1, 8'h10, 8'hA5);
    batch(4'b0010, 4'b0000, 1, 1'b0);
    setup(1, 1'b0, 8'h10, 8'h00);
    batch(4'b0010, 4'b0000, 1, 1'b0);
    chk("single_read", 32'(bus.rdata), 32'hA5);
    lat = 0;
    setup(2, 1'b0, 8'h30, 8'h00);
    batch(4'b0100, 4'b0000, 1, 1'b0);
    chk("timeout_rdata_held", 32'(bus.rdata), 32'hA5);
    setup(2, 1'b1, 8'h40, 8'h77);
    batch(4'b0100, 4'b0000, 1, 1'b0);
    setup(2, 1'b0, 8'h10, 8'h00);
    bus.req[2] = 1'b1;
    repeat (2) @(negedge clock);
    chk("mid_wait_grant", 32'(bus.grant), 32'h4);
    reset = 1'b1;
    bus.req = '0;
    @(negedge clock);
    chk("rst_mid_outputs", {bus.grant, bus.done, bus.err, bus.bank_read, bus.bank_write}, 0);
    chk("rst_mid_rdata", 32'(bus.rdata), 0);
    reset = 1'b0;
    ptr_m = 0;
    exp_rd = 8'h00;
    lat = 1;
    @(negedge clock);
    chk("rst_no_pulse", {bus.done, bus.err}, 0);
    setup(1, 1'b0, 8'h10, 8'h00);
    setup(3, 1'b0, 8'h40, 8'h00);
    batch(4'b1010, 4'b0000, 2, 1'b0);
    chk("post_rst_order", ord, 32'h24);
    chk("timeout_write_landed", 32'(bus.rdata), 32'h77);
    setup(0, 1'b1, 8'h7F, 8'h3C);
    batch(4'b0001, 4'b0000, 1, 1'b0);
    setup(3, 1'b0, 8'h7F, 8'h00);
    batch(4'b1000, 4'b0000, 1, 1'b0);
    chk("wr_rd_rdata", 32'(bus.rdata), 32'h3C);
    for (int a = 8'hF0; a <= 8'hFF; a++) begin
      int r = $urandom_range(0, N - 1);
      setup(r, 1'b1, 8'(a), 8'($urandom));
      batch(N'(1) << r, '0, 1, 1'b0);
    end
    for (int b = 0; b < 30; b++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      h = N'($urandom) & m & N'({$urandom_range(0, 1)} * 4'hF);
      for (int i = 0; i < N; i++)
        setup(i, 1'($urandom), 8'($urandom_range(8'hF0, 8'hFF)), 8'($urandom));
      lat = $urandom_range(0, 4);
      batch(m, h, $countones(m) + (h != 0 ? $urandom_range(1, 4) : 0), 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
